// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART TX arbiter.
package uart_pkg;

  localparam int UART_NUM_REQ      = 4;
  localparam int UART_BUSY_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin pick: first set request above i_last, wrapping.
module uart_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  output logic               o_any,
  output logic [IW-1:0]      o_idx
);

  logic [IW:0] w_sum;

  assign o_any = |i_req;

  // Walk from lowest to highest priority so the nearest match wins.
  always_comb begin
    o_idx = '0;
    w_sum = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_sum = {1'b0, i_last} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NUM_REQ))
        w_sum = w_sum - (IW+1)'(NUM_REQ);
      if (i_req[w_sum[IW-1:0]])
        o_idx = w_sum[IW-1:0];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NUM_REQ requesters
// into one UART transmitter, with a busy-handshake timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ      = UART_NUM_REQ,
  parameter  int BUSY_TIMEOUT = UART_BUSY_TIMEOUT,
  localparam int IW           = $clog2(NUM_REQ),
  localparam int CW           = $clog2(BUSY_TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [IW-1:0]        grant_id,
  output logic                 grant_active,
  output logic                 err_timeout
);

  arb_state_e    r_state;
  arb_state_e    w_next;
  logic [IW-1:0] r_last;
  logic [IW-1:0] r_gid;
  logic [IW-1:0] w_win;
  logic [7:0]    r_data;
  logic [CW-1:0] r_cnt;
  logic          w_any;
  logic          w_expired;
  logic          w_release;

  uart_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .i_req (req_valid),
    .i_last(r_last),
    .o_any (w_any),
    .o_idx (w_win)
  );

  // r_cnt counts completed WAIT_BUSY cycles; this one is the last allowed.
  assign w_expired    = (r_cnt >= CW'(BUSY_TIMEOUT - 1));
  assign tx_data      = r_data;
  assign grant_id     = r_gid;
  assign grant_active = (r_state != ST_IDLE);

  always_comb begin
    w_next      = r_state;
    w_release   = 1'b0;
    tx_start    = 1'b0;
    req_ready   = '0;
    err_timeout = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) w_next = ST_START;
      end
      ST_START: begin
        tx_start         = 1'b1;
        req_ready[r_gid] = 1'b1;
        w_next           = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          w_next = ST_WAIT_DONE;
        end else if (w_expired) begin
          err_timeout = 1'b1;
          w_release   = 1'b1;
          w_next      = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          w_release = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_last  <= IW'(NUM_REQ - 1);
      r_gid   <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_any) begin
        r_gid  <= w_win;
        r_data <= req_data[{w_win, 3'b000} +: 8];
      end
      if (w_release) r_last <= r_gid;
      if (r_state != ST_WAIT_BUSY)
        r_cnt <= '0;
      else if (r_cnt != CW'(BUSY_TIMEOUT))
        r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: transaction-level arbiter model,
// UART transmitter/receiver models and per-requester byte FIFOs.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TO  = 16;
  localparam int BIT = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*8-1:0]   req_data = '0;
  logic [N-1:0]     req_ready;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_busy = 1'b0;
  logic [$clog2(N)-1:0] grant_id;
  logic             grant_active;
  logic             err_timeout;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .BUSY_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .grant_id(grant_id),
    .grant_active(grant_active),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  logic [7:0] src_q[N][$];
  logic [7:0] exp_q[N][$];
  int         ord_q[$];
  int         gq[$];
  int         gaps[$];
  logic [7:0] rx_log[$];
  bit         pop[N];
  int         rdy_cnt[N];
  int         err_cnt = 0;
  int         err_cyc = 0;
  int         start_cyc = 0;
  int         fall_cyc = -1;
  int         cyc = 0;
  bit         uart_en = 1'b1;

  int         u_lat = 0;
  int         u_bit = 0;
  int         u_cnt = 0;
  logic [9:0] u_frame = '1;
  logic       tx_line = 1'b1;

  function automatic int rr(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic push_req(int i, logic [7:0] b);
    src_q[i].push_back(b);
    exp_q[i].push_back(b);
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
      pop[i] = 1'b0;
      rdy_cnt[i] = 0;
    end
    ord_q.delete();
    gq.delete();
    gaps.delete();
    rx_log.delete();
    err_cnt = 0;
    fall_cyc = -1;
  endtask

  // Requesters and UART transmitter: drive shortly after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst) begin
      u_lat = 0; u_bit = 0; u_cnt = 0;
      tx_busy = 1'b0; tx_line = 1'b1;
    end else if (u_lat > 0) begin
      u_lat--;
      if (u_lat == 0) begin
        tx_busy = 1'b1; u_bit = 0; u_cnt = 0;
        tx_line = u_frame[0];
      end
    end else if (tx_busy) begin
      u_cnt++;
      if (u_cnt == BIT) begin
        u_cnt = 0;
        u_bit++;
        if (u_bit == 10) begin
          tx_busy = 1'b0; tx_line = 1'b1; fall_cyc = cyc;
        end else begin
          tx_line = u_frame[u_bit];
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (pop[i]) begin
        if (src_q[i].size() > 0) void'(src_q[i].pop_front());
        pop[i] = 1'b0;
      end
      req_valid[i] = (src_q[i].size() > 0);
      req_data[8*i +: 8] = req_valid[i] ? src_q[i][0] : 8'($urandom);
    end
  end

  // Transaction-level arbiter model, compared every cycle out of reset.
  bit         m_active, m_start, m_seen;
  int         m_last, m_gid, m_wait;
  logic [7:0] m_data;

  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    logic         exp_err;
    int           w;
    if (!rst) begin
      m_active = 0; m_start = 0; m_seen = 0;
      m_last = N - 1; m_gid = 0; m_wait = 0; m_data = '0;
    end else begin
      exp_rdy = m_start ? (N'(1) << m_gid) : '0;
      exp_err = m_active && !m_start && !m_seen && !tx_busy && (m_wait == TO);
      chk("tx_start", tx_start, m_start);
      chk("grant_active", grant_active, m_active);
      chk("grant_id", grant_id, m_gid);
      chk("tx_data", tx_data, m_data);
      chk("req_ready", req_ready, exp_rdy);
      chk("err_timeout", err_timeout, exp_err);
      for (int i = 0; i < N; i++) if (req_ready[i]) rdy_cnt[i]++;
      if (err_timeout) begin err_cnt++; err_cyc = cyc; end
      if (m_start) begin
        gq.push_back(m_gid);
        ord_q.push_back(m_gid);
        start_cyc = cyc;
        pop[m_gid] = 1'b1;
        if (fall_cyc >= 0) begin gaps.push_back(cyc - fall_cyc); fall_cyc = -1; end
        if (uart_en) begin
          u_lat = $urandom_range(1, 3);
          u_frame = {1'b1, m_data, 1'b0};
        end
      end
      if (!m_active) begin
        w = rr(req_valid, m_last);
        if (w >= 0) begin
          m_gid = w; m_data = req_data[8*w +: 8];
          m_start = 1; m_active = 1; m_seen = 0; m_wait = 0;
        end
      end else if (m_start) begin
        m_start = 0; m_wait = 1;
      end else if (!m_seen) begin
        if (tx_busy) m_seen = 1;
        else if (m_wait == TO) begin m_active = 0; m_last = m_gid; end
        m_wait++;
      end else if (!tx_busy) begin
        m_active = 0; m_last = m_gid;
      end
    end
  end

  // 8N1 receiver on the serial line, checked against per-requester FIFOs.
  bit         r_on = 0;
  int         r_n = 0;
  logic [7:0] r_sh = '0;

  always @(negedge clk) begin
    int id;
    if (!rst) begin
      r_on = 0;
    end else if (!r_on) begin
      if (tx_line == 1'b0) begin r_on = 1; r_n = 0; end
    end else begin
      r_n++;
      if (r_n > BIT && r_n < 9*BIT && (r_n % BIT) == BIT/2)
        r_sh = {tx_line, r_sh[7:1]};
      if (r_n == 9*BIT + BIT/2) begin
        chk("rx_stop", tx_line, 1);
        r_on = 0;
        rx_log.push_back(r_sh);
        if (ord_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rx_order: got byte %0h want none", r_sh);
        end else begin
          id = ord_q.pop_front();
          if (exp_q[id].size() == 0) begin
            total++; bad++;
            $display("FAIL rx_fifo: got byte %0h want empty req %0d", r_sh, id);
          end else begin
            chk("rx_byte", r_sh, exp_q[id].pop_front());
          end
        end
      end
    end
  end

  task automatic wait_rx(int n, int lim);
    int k = 0;
    while (rx_log.size() < n && k < lim) begin @(negedge clk); k++; end
    #1;
    chk("wait_rx", rx_log.size(), n);
  endtask

  task automatic apply_reset();
    @(posedge clk); #2; rst = 1'b0;
    clear_all();
    repeat (2) @(posedge clk);
    #2; rst = 1'b1;
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_grant_active"}, grant_active, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  function automatic int gat(int i);
    return (i < gq.size()) ? gq[i] : -1;
  endfunction

  function automatic int rat(int i);
    return (i < rx_log.size()) ? int'(rx_log[i]) : -1;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int sent;
    int nb;
    clear_all();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    #1; rst = 1'b1;

    // Single request from requester 2.
    push_req(2, 8'h41);
    wait_rx(1, 200);
    chk("t1_byte", rat(0), 8'h41);
    chk("t1_ngrant", gq.size(), 1);
    chk("t1_grant", gat(0), 2);
    chk("t1_grant_id", grant_id, 2);
    chk("t1_ready2", rdy_cnt[2], 1);
    chk("t1_ready_all", rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[3], 0);

    // All four at once after reset.
    apply_reset();
    for (int i = 0; i < N; i++) push_req(i, 8'hA0 + 8'(i));
    wait_rx(4, 600);
    for (int i = 0; i < N; i++) begin
      chk("t2_grant", gat(i), i);
      chk("t2_byte", rat(i), 8'hA0 + i);
    end
    chk("t2_ngaps", gaps.size(), 3);
    foreach (gaps[i]) chk("t2_idle_gap", gaps[i], 2);

    // Fairness between requesters 1 and 3.
    apply_reset();
    for (int j = 0; j < 3; j++) begin
      push_req(1, 8'h10 + 8'(j));
      push_req(3, 8'h30 + 8'(j));
    end
    wait_rx(6, 800);
    for (int j = 0; j < 6; j++) begin
      chk("t3_grant", gat(j), (j % 2 == 0) ? 1 : 3);
      chk("t3_byte", rat(j), ((j % 2 == 0) ? 8'h10 : 8'h30) + j / 2);
    end

    // Busy timeout with a silent transmitter.
    apply_reset();
    uart_en = 1'b0;
    push_req(1, 8'h55);
    k = 0;
    while (err_cnt < 1 && k < 100) begin @(negedge clk); k++; end
    #1;
    chk("t4_err_cnt", err_cnt, 1);
    chk("t4_err_delay", err_cyc - start_cyc, 16);
    push_req(0, 8'h60);
    push_req(1, 8'h61);
    push_req(2, 8'h62);
    k = 0;
    while (err_cnt < 4 && k < 300) begin @(negedge clk); k++; end
    #1;
    chk("t4_err_total", err_cnt, 4);
    chk("t4_grant0", gat(0), 1);
    chk("t4_grant1", gat(1), 2);
    chk("t4_grant2", gat(2), 0);
    chk("t4_grant3", gat(3), 1);
    chk("t4_no_rx", rx_log.size(), 0);
    uart_en = 1'b1;

    // Reset while the transmitter is busy.
    apply_reset();
    push_req(2, 8'h99);
    k = 0;
    while (!(tx_busy && grant_active) && k < 50) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    chk("t5_in_wait_done", {31'b0, grant_active & tx_busy}, 1);
    @(posedge clk); #3; rst = 1'b0; #1;
    check_reset_vals("t5_async");
    repeat (3) begin
      @(negedge clk);
      chk("t5_ready_in_rst", req_ready, 0);
      chk("t5_err_in_rst", err_timeout, 0);
    end
    clear_all();
    @(posedge clk); #2; rst = 1'b1;
    push_req(3, 8'hB3);
    push_req(0, 8'hB0);
    wait_rx(2, 400);
    chk("t5_first_grant", gat(0), 0);
    chk("t5_second_grant", gat(1), 3);
    chk("t5_byte0", rat(0), 8'hB0);
    chk("t5_byte1", rat(1), 8'hB3);

    // Random traffic: 256 bytes from random requesters.
    apply_reset();
    sent = 0;
    while (sent < 256) begin
      nb = $urandom_range(1, 4);
      for (int j = 0; j < nb && sent < 256; j++) begin
        push_req($urandom_range(0, N - 1), 8'($urandom));
        sent++;
      end
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    wait_rx(256, 40000);
    chk("t6_ord_left", ord_q.size(), 0);
    for (int i = 0; i < N; i++) chk("t6_fifo_left", exp_q[i].size(), 0);
    chk("t6_no_timeout", err_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 16: maximum cycles from tx_start to tx_busy rising.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, NUM_REQ: per-requester byte pending.
REQ-006 SHALL have port req_data, input, NUM_REQ*8: per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 SHALL have port req_ready, output, NUM_REQ: one-cycle accept pulse per requester.
REQ-008 SHALL have port tx_start, output, 1: start pulse to the UART transmitter.
REQ-009 SHALL have port tx_data, output, 8: byte to the UART transmitter.
REQ-010 SHALL have port tx_busy, input, 1: UART transmitter busy.
REQ-011 SHALL have port grant_id, output, $clog2(NUM_REQ): index of the current or last granted requester.
REQ-012 SHALL have port grant_active, output, 1: high from START through WAIT_DONE.
REQ-013 SHALL have port err_timeout, output, 1: one-cycle pulse when a busy timeout occurs.

Function
REQ-014 SHALL implement FSM states IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-015 IDLE: with any req_valid high, SHALL go to START at the next edge, latching the winner's req_data into tx_data and the winner's index into grant_id.
REQ-016 IDLE with no req_valid high SHALL remain in IDLE.
REQ-017 Winner SHALL be chosen round-robin: first valid index searching upward from last_grant+1, wrapping NUM_REQ-1 -> 0.
REQ-018 After reset, last_grant SHALL be NUM_REQ-1, so requester 0 has first priority.
REQ-019 START SHALL last exactly one cycle.
- tx_start=1 and req_ready[grant_id]=1 in that cycle only.
- Next state WAIT_BUSY.
REQ-020 Requesters SHALL hold req_valid and req_data stable until req_ready; after the accept pulse the arbiter SHALL ignore req_data changes.
REQ-021 WAIT_BUSY: tx_busy=1 -> WAIT_DONE.
REQ-022 WAIT_BUSY: BUSY_TIMEOUT cycles elapsed without tx_busy -> pulse err_timeout, go to IDLE, update last_grant.
REQ-023 WAIT_DONE: tx_busy=0 -> IDLE, last_grant <= grant_id.
REQ-024 Back-to-back grants SHALL be separated by exactly one IDLE cycle.
REQ-025 tx_data SHALL stay constant from START until the next START.
REQ-026 The timeout counter SHALL clear on entry to WAIT_BUSY and saturate at BUSY_TIMEOUT.
REQ-027 A requester dropping req_valid before the grant SHALL simply not be selected; there is no error.
REQ-028 req_valid changes during START, WAIT_BUSY or WAIT_DONE SHALL NOT affect the current transfer.

Reset
REQ-029 Reset assertion SHALL immediately force state IDLE, regardless of the current state.
REQ-030 Reset SHALL force outputs: tx_start=0, tx_data=8'h00, req_ready=0, grant_id=0, grant_active=0, err_timeout=0.
REQ-031 Reset SHALL set last_grant=NUM_REQ-1 and timeout counter=0.
REQ-032 Reset mid-transfer SHALL abandon the grant without issuing req_ready or err_timeout.
REQ-033 Release of reset SHALL be synchronized externally; the first edge after release SHALL evaluate IDLE.

Structure
REQ-034 A shared package uart_pkg SHALL hold:
- arbiter state enum
- default NUM_REQ and BUSY_TIMEOUT constants
REQ-035 Round-robin selection SHALL be a combinational sub-module uart_rr_pick.
- Inputs: request vector, last_grant.
- Outputs: any_valid, winner index.
REQ-036 FSM, data latch and timeout counter SHALL reside in uart_tx_arbiter.

Verification
REQ-037 Single request, with a UART transmitter model at 100 MHz / 10416 clks per bit:
- Stimulus: req_valid=4'b0100, req_data[23:16]=8'h41.
- Response: req_ready[2] pulses once; tx_start one cycle later than IDLE; tx line carries 0x41 framed 8N1; grant_id=2.
REQ-038 All four valid simultaneously, bytes 8'hA0..8'hA3:
- Response: grant order 0,1,2,3; serial output A0,A1,A2,A3.
- Check: exactly one IDLE cycle between tx_busy falling and the next tx_start.
REQ-039 Fairness:
- Stimulus: requesters 1 and 3 continuously valid for 6 grants.
- Response: grants alternate 1,3,1,3,1,3.
REQ-040 Timeout:
- Stimulus: tx_busy tied low, one request.
- Response: err_timeout pulses exactly 16 cycles after tx_start; FSM returns to IDLE; the next grant goes to the following requester.
REQ-041 Reset mid-transfer:
- Stimulus: rst low during WAIT_DONE.
- Response: outputs match reset values immediately; no req_ready pulse; requester 0 is granted first after release.
REQ-042 Random self-checking run, 256 random bytes from random requesters:
- Check: received bytes match a per-requester FIFO model; zero fails.
